memory_access: RTL

Pipeline stage directly downstream of the execute stage. Consumes the executed instruction (decoded op, ALU result, rs2 value) and performs LOAD/STORE transactions on a simple request/response data-memory port. Size-aligns and extends load data. Presents a registered result to the writeback stage over a valid/ready handshake. Non-memory ops pass through with one cycle of latency.

---
 rtl/memory_access.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_access: LOAD/STORE stage between execute and writeback (rev 1.0)    |
// +----------------------------------------------------------------------------+
module memory_access #(
  parameter int         XLEN     = 32,
  parameter logic [4:0] OP_LOAD  = 5'd1,
  parameter logic [4:0] OP_STORE = 5'd2
) (
  input  logic            clk,
  input  logic            rstf,
  input  logic [31:0]     t_instr,
  input  logic            t_instr_valid,
  output logic            t_instr_ready,
  input  logic [XLEN-1:0] iPC,
  input  logic [4:0]      iDecodedOP,
  input  logic [XLEN-1:0] aluValue,
  input  logic [XLEN-1:0] rs2Value,
  output logic [31:0]     i_instr,
  output logic            i_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] oPC,
  output logic [4:0]      oDecodedOP,
  output logic [XLEN-1:0] oResult,
  output logic            oFault,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t r_state, w_state_next;

  logic [XLEN-1:0] r_addr, r_store_data, r_pc;
  logic [31:0]     r_instr;
  logic [4:0]      r_op;
  logic [2:0]      r_f3;
  logic            r_is_store;

  logic       w_accept, w_is_load, w_is_store, w_is_mem;
  logic       w_size_ok, w_misaligned, w_mem_fault;
  logic [2:0] w_f3;

  assign t_instr_ready = (r_state == IDLE) && (!i_instr_valid || i_instr_ready);
  assign w_accept      = t_instr_valid && t_instr_ready;
  assign w_f3          = t_instr[14:12];
  assign w_is_load     = (iDecodedOP == OP_LOAD);
  assign w_is_store    = (iDecodedOP == OP_STORE);
  assign w_is_mem      = w_is_load || w_is_store;

  always_comb begin
    w_size_ok = 1'b0;
    if (w_is_load)
      w_size_ok = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2) ||
                  (w_f3 == 3'd4) || (w_f3 == 3'd5);
    else if (w_is_store)
      w_size_ok = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2);
  end

  // f3[1:0] encodes access size for both signed and unsigned loads
  assign w_misaligned = ((w_f3[1:0] == 2'b01) && aluValue[0]) ||
                        ((w_f3[1:0] == 2'b10) && (aluValue[1:0] != 2'b00));
  assign w_mem_fault  = w_is_mem && (!w_size_ok || w_misaligned);

  always_ff @(posedge clk) begin
    if (rstf) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mem && !w_mem_fault) w_state_next = REQ;
      REQ:     if (dmem_req_ready) w_state_next = r_is_store ? IDLE : RESP;
      RESP:    if (dmem_rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstf) begin
      r_addr       <= '0;
      r_store_data <= '0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_op         <= '0;
      r_f3         <= '0;
      r_is_store   <= 1'b0;
    end else if (w_accept && w_is_mem) begin
      r_addr       <= aluValue;
      r_store_data <= rs2Value;
      r_pc         <= iPC;
      r_instr      <= t_instr;
      r_op         <= iDecodedOP;
      r_f3         <= w_f3;
      r_is_store   <= w_is_store;
    end
  end

  // Bus fields come straight from the latched transaction, so they hold through REQ
  assign dmem_req_valid = (r_state == REQ);
  assign dmem_we        = r_is_store;
  assign dmem_addr      = {r_addr[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_wdata = r_store_data;
    dmem_wstrb = 4'b0000;
    if (r_is_store) begin
      case (r_f3[1:0])
        2'b00: begin
          dmem_wdata = {4{r_store_data[7:0]}};
          dmem_wstrb = 4'b0001 << r_addr[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{r_store_data[15:0]}};
          dmem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = r_store_data;
          dmem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;

  assign w_byte = dmem_rdata[8*r_addr[1:0] +: 8];
  assign w_half = dmem_rdata[16*r_addr[1] +: 16];

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_f3)
      3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {24'd0, w_byte};
      3'd5:    w_load_data = {16'd0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Accepts only happen when the register is empty or draining, so loads never overwrite
  always_ff @(posedge clk) begin
    if (rstf) begin
      i_instr_valid <= 1'b0;
      i_instr       <= '0;
      oPC           <= '0;
      oDecodedOP    <= '0;
      oResult       <= '0;
      oFault        <= 1'b0;
    end else begin
      if (i_instr_valid && i_instr_ready) i_instr_valid <= 1'b0;
      if (w_accept && (!w_is_mem || w_mem_fault)) begin
        i_instr_valid <= 1'b1;
        i_instr       <= t_instr;
        oPC           <= iPC;
        oDecodedOP    <= iDecodedOP;
        oResult       <= aluValue;
        oFault        <= w_mem_fault;
      end else if ((r_state == REQ && dmem_req_ready && r_is_store) ||
                   (r_state == RESP && dmem_rvalid)) begin
        i_instr_valid <= 1'b1;
        i_instr       <= r_instr;
        oPC           <= r_pc;
        oDecodedOP    <= r_op;
        oResult       <= (r_state == RESP) ? w_load_data : r_addr;
        oFault        <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
